gf_mult: RTL and testbench

- Bit-serial GF(2^m) multiplier over the polynomial basis for the ECC datapath. Default field is GF(2^163) with reduction polynomial x^163+x^7+x^6+x^3+1.
- Sits alongside gf_Div in the point-arithmetic chain. It consumes the divider quotient Q (slope lambda) and produces lambda*lambda and lambda*(x1+x3) terms for the point add/double controller.
- Operand and result widths match the gf_Div interface, so Q can be wired straight into A or B.

---
 rtl/gf_mult.sv | 141 ++++++++++++++
 tb/tb_gf_mult.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult.sv
`default_nettype none
// ============================================================================
//  Module      : gf_mult
//  Description : Bit-serial GF(2^m) multiplier, polynomial basis, MSB-first.
//                Computes P = A*B mod f(x), with f(x) = x^NUM_BITS + POLY_LOW.
//                One multiplier bit is consumed per clock; the product is
//                available NUM_BITS clocks after start is accepted.
//  Ports       :
//     clk    in   system clock, all state changes on the rising edge
//     rst    in   synchronous active-high reset
//     A      in   multiplicand [NUM_BITS:0], top bit ignored
//     B      in   multiplier   [NUM_BITS:0], top bit ignored
//     start  in   request, accepted in IDLE or DONE only
//     P      out  reduced product [NUM_BITS:0], top bit always 0
//     busy   out  high while iterating
//     done   out  single-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module gf_mult #(
   parameter int                  NUM_BITS = 163,
   parameter logic [NUM_BITS-1:0] POLY_LOW = 'hC9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_BITS:0] A,
   input  logic [NUM_BITS:0] B,
   input  logic              start,
   output logic [NUM_BITS:0] P,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]          state;
   logic [1:0]          state_next;
   logic                load;
   logic                step;
   logic                last_step;

   logic [NUM_BITS-1:0] a_reg;
   logic [NUM_BITS-1:0] b_reg;
   logic [NUM_BITS-1:0] acc;
   logic [NUM_BITS-1:0] acc_next;
   logic [NUM_BITS-1:0] prod;
   logic [CNT_W-1:0]    count;

   // Operand MSBs are architecturally don't-care.
   logic                unused_msbs;
   assign unused_msbs = A[NUM_BITS] ^ B[NUM_BITS];

   assign last_step = (count == '0);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start)     state_next = ST_BUSY;
         ST_BUSY: if (last_step) state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_BUSY : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      load = 1'b0;
      step = 1'b0;
      case (state)
         ST_IDLE: load = start;
         ST_BUSY: begin
            busy = 1'b1;
            step = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
            load = start;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- step logic
   // Horner step: multiply accumulator by x (reducing the overflow term
   // x^NUM_BITS into POLY_LOW), then add A if the current multiplier bit is
   // set. b_reg is shifted left each step so its MSB is always Breg[count].
   always_comb begin
      acc_next = {acc[NUM_BITS-2:0], 1'b0};
      if (acc[NUM_BITS-1]) begin
         acc_next = acc_next ^ POLY_LOW;
      end
      if (b_reg[NUM_BITS-1]) begin
         acc_next = acc_next ^ a_reg;
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         count <= '0;
         prod  <= '0;
      end else if (load) begin
         a_reg <= A[NUM_BITS-1:0];
         b_reg <= B[NUM_BITS-1:0];
         acc   <= '0;
         count <= CNT_LAST;
      end else if (step) begin
         acc   <= acc_next;
         b_reg <= {b_reg[NUM_BITS-2:0], 1'b0};
         if (last_step) begin
            // Product is held here until the next completion or reset.
            prod <= acc_next;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   assign P = {1'b0, prod};

endmodule
`default_nettype wire

// File: tb/tb_gf_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf_mult
//  Description : Self-checking bench for gf_mult (GF(2^163) default field).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gf_mult;

   localparam int N   = 163;
   localparam int LAT = 163;

   logic         clk;
   logic         rst;
   logic [N:0]   A;
   logic [N:0]   B;
   logic         start;
   logic [N:0]   P;
   logic         busy;
   logic         done;

   int checks;
   int errors;

   gf_mult dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .start (start),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full carry-less product, then reduce from the top down.
   function automatic logic [N-1:0] gf_model(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] prodw;
      logic [2*N-1:0] poly;
      prodw = '0;
      poly  = '0;
      poly[N] = 1'b1;
      poly[7] = 1'b1;
      poly[6] = 1'b1;
      poly[3] = 1'b1;
      poly[0] = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (b[i]) prodw = prodw ^ ({{N{1'b0}}, a} << i);
      end
      for (int k = 2*N-2; k >= N; k--) begin
         if (prodw[k]) prodw = prodw ^ (poly << (k - N));
      end
      return prodw[N-1:0];
   endfunction

   // Drive start for exactly one rising edge; operands are scrambled
   // afterwards so the DUT must rely on its latched copies.
   task automatic do_start(input logic [N:0] a, input logic [N:0] b);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = '1;
      B = '1;
   endtask

   // Number of edges after the start edge until done is seen (bounded).
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 400) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      A = 164'h5;
      B = 164'h3;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (P !== '0) begin
         errors++;
         $display("FAIL reset_p: got %h expected 0", P);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", busy, done);
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_op: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_basic();
      int bad_busy;
      bad_busy = 0;
      do_start(164'h1, 164'h2);
      // After start edge (edge 0) through edge 162: busy=1, done=0.
      for (int c = 0; c < LAT; c++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         if (c < LAT - 1) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL basic_busy: got %0d bad cycles expected 0", bad_busy);
      end
      @(posedge clk); #1;   // edge 163
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_edge: got busy=%b done=%b expected 0/1", busy, done);
      end
      checks++;
      if (P !== 164'h2) begin
         errors++;
         $display("FAIL basic_p: got %h expected 2", P);
      end
      @(posedge clk); #1;   // edge 164
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%b expected 0", done);
      end
   endtask

   task automatic test_reduction();
      int cyc;
      logic [N:0] a;
      a = '0;
      a[162] = 1'b1;
      do_start(a, 164'h2);
      wait_done(cyc);
      checks++;
      if (cyc != LAT || P !== 164'hC9) begin
         errors++;
         $display("FAIL single_reduction: got P=%h lat=%0d expected C9 lat=%0d", P, cyc, LAT);
      end
      a = '0;
      a[100] = 1'b1;
      @(posedge clk); #1;
      do_start(a, a);
      wait_done(cyc);
      a = '0;
      a[44] = 1'b1;
      a[43] = 1'b1;
      a[40] = 1'b1;
      a[37] = 1'b1;
      checks++;
      if (cyc != LAT || P !== a) begin
         errors++;
         $display("FAIL wide_reduction: got P=%h lat=%0d expected %h", P, cyc, a);
      end
   endtask

   task automatic test_random();
      logic [191:0] t;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic [N-1:0] exp_p;
      logic [N:0]   p_ab;
      int cyc;
      for (int i = 0; i < 20; i++) begin
         t  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         ra = t[N-1:0];
         t  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         rb = t[N-1:0];
         exp_p = gf_model(ra, rb);
         @(posedge clk); #1;
         do_start({1'b0, ra}, {1'b0, rb});
         wait_done(cyc);
         p_ab = P;
         checks++;
         if (cyc != LAT || p_ab !== {1'b0, exp_p}) begin
            errors++;
            $display("FAIL random_ab[%0d]: got %h lat=%0d expected %h", i, p_ab, cyc, exp_p);
         end
         @(posedge clk); #1;
         do_start({1'b0, rb}, {1'b0, ra});
         wait_done(cyc);
         checks++;
         if (cyc != LAT || P !== p_ab) begin
            errors++;
            $display("FAIL random_ba[%0d]: got %h lat=%0d expected %h", i, P, cyc, p_ab);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      logic [N:0] a;
      a = '0;
      a[162] = 1'b1;
      @(posedge clk); #1;
      do_start(a, 164'h4);   // x^164 = x * (x^7+x^6+x^3+1)
      repeat (49) @(posedge clk);
      #1;
      A = 164'h7;
      B = 164'h7;
      start = 1'b1;
      @(posedge clk); #1;    // edge 50
      start = 1'b0;
      wait_done(cyc);
      checks++;
      if (cyc + 50 != LAT || P !== 164'h192) begin
         errors++;
         $display("FAIL start_in_busy: got P=%h lat=%0d expected 192 lat=%0d", P, cyc + 50, LAT);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int held_bad;
      held_bad = 0;
      @(posedge clk); #1;
      do_start(164'h7, 164'h3);   // (x^2+x+1)(x+1) = x^3+1
      wait_done(cyc);
      checks++;
      if (cyc != LAT || P !== 164'h9) begin
         errors++;
         $display("FAIL b2b_first: got P=%h lat=%0d expected 9", P, cyc);
      end
      // In the DONE cycle: request again.
      do_start(164'h6, 164'h6);   // (x^2+x)^2 = x^4+x^2
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_gap: got busy=%b done=%b expected 1/0", busy, done);
      end
      cyc = 0;
      while (!done && cyc < 400) begin
         if (P !== 164'h9) held_bad++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (held_bad != 0) begin
         errors++;
         $display("FAIL b2b_p_held: got %0d cycles with P changed expected 0", held_bad);
      end
      checks++;
      if (cyc != LAT || P !== 164'h14) begin
         errors++;
         $display("FAIL b2b_second: got P=%h lat=%0d expected 14", P, cyc);
      end
   endtask

   task automatic test_reset_mid_op();
      int cyc;
      int saw_done;
      saw_done = 0;
      @(posedge clk); #1;
      do_start(164'h5, 164'h7);
      repeat (79) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;    // edge 80
      rst = 1'b0;
      checks++;
      if (P !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got P=%h busy=%b done=%b expected 0/0/0", P, busy, done);
      end
      for (int c = 0; c < 120; c++) begin
         if (done !== 1'b0) saw_done++;
         @(posedge clk); #1;
      end
      checks++;
      if (saw_done != 0) begin
         errors++;
         $display("FAIL mid_reset_no_done: got %0d done cycles expected 0", saw_done);
      end
      do_start(164'h3, 164'h3);   // (x+1)^2 = x^2+1
      wait_done(cyc);
      checks++;
      if (cyc != LAT || P !== 164'h5) begin
         errors++;
         $display("FAIL after_reset: got P=%h lat=%0d expected 5", P, cyc);
      end
   endtask

   task automatic test_ignored_msb();
      int cyc;
      logic [N:0] a;
      a = 164'h5;
      a[N] = 1'b1;
      @(posedge clk); #1;
      do_start(a, 164'h3);   // (x^2+1)(x+1) = x^3+x^2+x+1
      wait_done(cyc);
      checks++;
      if (cyc != LAT || P !== 164'hF) begin
         errors++;
         $display("FAIL ignored_msb: got P=%h lat=%0d expected F", P, cyc);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      A      = '0;
      B      = '0;
      #1;
      test_reset();
      test_basic();
      test_reduction();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      test_ignored_msb();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
